// File: rtl/yuv444_to_yuv422.sv
// 4:4:4 to 4:2:2 packer: pairs pixels into {Y,Cb} / {Y,Cr} words, optionally
// averaging chroma across the pair, with start-of-line realignment.
module yuv444_to_yuv422 #(
  parameter int AVERAGE = 1
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [7:0]  iY,
  input  logic [7:0]  iCb,
  input  logic [7:0]  iCr,
  input  logic        iValid,
  input  logic        iSOL,
  output logic [15:0] oYCbCr,
  output logic        oValid,
  output logic        oCrSel,
  output logic        oSOL
);

  localparam int DATA_W = 8;

  typedef enum logic {EVEN_WAIT, ODD_WAIT} phase_t;

  phase_t                phase;
  logic [DATA_W-1:0]     yHeld_p0, cbHeld_p0, crHeld_p0;
  logic                  solHeld_p0;
  logic [2*DATA_W-1:0]   word2_p1;
  logic                  vld2_p1;

  logic [DATA_W-1:0]     cbPair, crPair;
  logic                  storePix, pairOdd, flushOrphan;

  // Rounded mean; the 9-bit sum cannot overflow (255+255+1 = 511).
  function automatic logic [DATA_W-1:0] avgRound(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, 1'b1};
    return s[DATA_W:1];
  endfunction

  always_comb begin
    cbPair      = cbHeld_p0;
    crPair      = crHeld_p0;
    if (AVERAGE != 0) begin
      cbPair = avgRound(cbHeld_p0, iCb);
      crPair = avgRound(crHeld_p0, iCr);
    end
    pairOdd     = iValid && (phase == ODD_WAIT) && !iSOL;
    flushOrphan = iValid && (phase == ODD_WAIT) && iSOL;
    storePix    = iValid && ((phase == EVEN_WAIT) || iSOL);
  end

  // Stage p0: hold even pixel; stage p1: park the Cr word of a formed pair
  always_ff @(posedge iCLK) begin
    if (storePix) begin
      yHeld_p0  <= iY;
      cbHeld_p0 <= iCb;
      crHeld_p0 <= iCr;
    end
    if (pairOdd)
      word2_p1 <= {iY, crPair};
  end

  // Output stage: control and registered outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      phase      <= EVEN_WAIT;
      solHeld_p0 <= 1'b0;
      vld2_p1    <= 1'b0;
      oYCbCr     <= '0;
      oValid     <= 1'b0;
      oCrSel     <= 1'b0;
      oSOL       <= 1'b0;
    end else begin
      oValid  <= 1'b0;
      oSOL    <= 1'b0;
      vld2_p1 <= 1'b0;

      // A pending Cr word never coincides with a pair or flush: the phase is
      // EVEN_WAIT on the cycle it is emitted.
      if (vld2_p1) begin
        oYCbCr <= word2_p1;
        oValid <= 1'b1;
        oCrSel <= 1'b1;
      end

      if (iValid) begin
        case (phase)
          EVEN_WAIT: begin
            solHeld_p0 <= iSOL;
            phase      <= ODD_WAIT;
          end
          ODD_WAIT: begin
            oValid <= 1'b1;
            oCrSel <= 1'b0;
            oSOL   <= solHeld_p0;
            if (iSOL) begin
              // Odd-length line: emit the orphan alone, new pixel becomes even
              oYCbCr     <= {yHeld_p0, cbHeld_p0};
              solHeld_p0 <= 1'b1;
            end else begin
              oYCbCr  <= {yHeld_p0, cbPair};
              vld2_p1 <= 1'b1;
              phase   <= EVEN_WAIT;
            end
          end
          default: phase <= EVEN_WAIT;
        endcase
      end
    end
  end

endmodule

// File: doc/yuv444_to_yuv422.md
Name: yuv444_to_yuv422

Overview:
- Packs a 4:4:4 pixel stream (separate Y/Cb/Cr bytes per pixel) into 4:2:2 16-bit words: {Y,Cb} for even pixels, {Y,Cr} for odd pixels.
- Used on the output side of the pipeline (after overlay/processing) to feed 4:2:2 sinks such as the SDRAM frame buffer or video encoder.
- Phase is tracked per accepted pixel and realigned on start-of-line.
- Chroma is optionally averaged across the pixel pair.

Parameters:
- AVERAGE, 1, 1 = chroma of each pair is the rounded mean of both pixels; 0 = chroma taken from the even pixel only.

Ports:
- iCLK  in  1  clock
- iRST_N  in  1  reset, asynchronous, active-low
- iY  in  8  luma of input pixel
- iCb  in  8  blue chroma of input pixel
- iCr  in  8  red chroma of input pixel
- iValid  in  1  input pixel valid, one pixel per cycle when high
- iSOL  in  1  start of line; qualified by iValid; marks the first pixel of a line
- oYCbCr  out  16  packed word: [15:8]=Y, [7:0]=Cb or Cr
- oValid  out  1  oYCbCr valid
- oCrSel  out  1  0 = low byte is Cb (even pixel), 1 = low byte is Cr (odd pixel)
- oSOL  out  1  high with the first output word of a line

Behaviour:
- Reset (iRST_N low, async):
  - oYCbCr=0, oValid=0, oCrSel=0, oSOL=0.
  - Phase cleared to EVEN, holding register empty, pending output cleared.
  - Reset mid-pair discards the held pixel. No output follows until a new pair arrives.
- Phase only advances on accepted pixels (iValid=1). Idle cycles never toggle phase.
- States:
  - EVEN_WAIT: no pixel held. An accepted pixel is stored (Y0, Cb0, Cr0, sol flag) and the state moves to ODD_WAIT.
  - ODD_WAIT: even pixel held. An accepted pixel without iSOL is the odd pixel (Y1, Cb1, Cr1); the pair is formed and the state returns to EVEN_WAIT.
  - An accepted pixel with iSOL in ODD_WAIT means an orphan even pixel (odd-length line); see the boundary rule below.
  - iSOL in EVEN_WAIT simply marks the stored pixel as line start.
- Pair output timing, odd pixel accepted at cycle t:
  - t+1: oValid=1, oCrSel=0, oYCbCr={Y0,Cb_out}, oSOL=stored sol flag.
  - t+2: oValid=1, oCrSel=1, oYCbCr={Y1,Cr_out}, oSOL=0.
  - All other cycles: oValid=0, oSOL=0. oYCbCr holds its last value.
  - Continuous input therefore gives a fixed 2-cycle pixel-to-word latency and a gap-free output stream.
- Chroma arithmetic:
  - AVERAGE=1: Cb_out=(Cb0+Cb1+1)>>1 and Cr_out=(Cr0+Cr1+1)>>1. The sum is computed in 9 bits, so no overflow (255+255+1 → 255).
  - AVERAGE=0: Cb_out=Cb0, Cr_out=Cr0.
- Orphan flush (iValid & iSOL while in ODD_WAIT):
  - Cycle after: emit the held pixel as a single word {Y0,Cb0} with oCrSel=0 and oSOL equal to its stored flag. No Cr word is emitted.
  - The new pixel is stored as the even pixel of the new line. State stays ODD_WAIT.
  - Output slots cannot collide, since a pair's second word always precedes any later flush or pair.
- iSOL with iValid=0 is ignored.
- Output words are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset, then 4 contiguous pixels Y=10,11,12,13 / Cb=100,102,50,51 / Cr=200,201,7,8, first with iSOL, AVERAGE=1 → words 0x0A65(oSOL=1), 0x0BC9, 0x0C33, 0x0D08 on consecutive cycles starting 2 cycles after the first pixel; oCrSel toggles 0,1,0,1.
- Same stimulus with AVERAGE=0 → 0x0A64, 0x0BC8, 0x0C32, 0x0D07.
- Pixels separated by 3 idle cycles → each pair still emits 2 back-to-back words one cycle after its odd pixel; phase is unaffected by idle cycles; no spurious oValid.
- 3-pixel line (iSOL on pixels 0 and 3), Y=1,2,3,4, Cb=0x10 each, Cr=0x20 each → 0x0110, 0x0220, 0x0310 (orphan, oCrSel=0), then 0x0410 with oSOL=1 once pixel 4 pairs; phase realigned.
- Chroma extremes Cb0=Cb1=255, Cr0=0, Cr1=1, AVERAGE=1 → Cb word byte 0xFF, Cr byte 0x01 (rounded up).
- Assert iRST_N low while an even pixel is held, release, then send one pair → all outputs 0 during reset; the held pixel never appears; the new pair emits exactly 2 words with oCrSel=0 then 1.
